// File: rtl/mac_tx_framer.sv
// mac_tx_framer: Ethernet byte-stream TX framer (preamble, SFD, data, CRC-32 FCS, inter-frame gap).
// Define MAC_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME bytes before the FCS.
module mac_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       phy_tx_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] mac_txd_in,
  input  logic       mac_tvalid_in,
  input  logic       mac_tlast_in,
  input  logic       mac_terr_in,
  output logic       mac_tready_out,
  output logic [7:0] phy_txd_out,
  output logic       phy_tvalid_out,
  input  logic       phy_tready_in,
  output logic       phy_terr_out,
  output logic       tx_done_out
);
  localparam int IW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

  state_t        state, state_nxt;
  logic [7:0]    txd_nxt;
  logic          tvalid_nxt, terr_nxt;
  logic          last_fcs, last_fcs_nxt;
  logic [10:0]   cnt, cnt_nxt, cnt_inc;
  logic [31:0]   crc, crc_nxt, fcs;
  logic [2:0]    sub, sub_nxt;
  logic [IW-1:0] ifg_cnt, ifg_nxt;
  logic          err, err_nxt;
  logic          drop, drop_nxt;
  logic          out_free, in_acc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {1'b0, r[31:1]} ^ ({32{r[0] ^ d[i]}} & 32'hEDB88320);
    return r;
  endfunction

  // The output register can take a new byte when empty or being drained this cycle.
  assign out_free       = !phy_tvalid_out || phy_tready_in;
  assign mac_tready_out = drop || (state == DATA && out_free);
  assign in_acc         = mac_tvalid_in && mac_tready_out;
  assign tx_done_out    = last_fcs && phy_tvalid_out && phy_tready_in;
  assign cnt_inc        = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
  // A frame that carried an upstream error gets a deliberately corrupted FCS.
  assign fcs            = err ? crc : ~crc;

  always_comb begin
    state_nxt    = state;
    txd_nxt      = phy_txd_out;
    tvalid_nxt   = phy_tvalid_out && !phy_tready_in;
    terr_nxt     = phy_terr_out;
    last_fcs_nxt = last_fcs && !phy_tready_in;
    cnt_nxt      = cnt;
    crc_nxt      = crc;
    sub_nxt      = sub;
    ifg_nxt      = ifg_cnt;
    err_nxt      = err;
    drop_nxt     = drop;
    if (drop && in_acc && mac_tlast_in) drop_nxt = 1'b0;
    case (state)
      IDLE: if (mac_tvalid_in && !drop && out_free) begin
        txd_nxt    = 8'h55;
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b0;
        sub_nxt    = 3'd1;
        cnt_nxt    = '0;
        crc_nxt    = '1;
        err_nxt    = 1'b0;
        state_nxt  = PREAMBLE;
      end
      PREAMBLE: if (out_free) begin
        txd_nxt    = 8'h55;
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b0;
        sub_nxt    = sub + 3'd1;
        if (sub == 3'd6) state_nxt = SFD;
      end
      SFD: if (out_free) begin
        txd_nxt    = 8'hD5;
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b0;
        sub_nxt    = 3'd0;
        state_nxt  = DATA;
      end
      DATA: if (in_acc) begin
        txd_nxt    = mac_txd_in;
        tvalid_nxt = 1'b1;
        terr_nxt   = mac_terr_in;
        err_nxt    = err | mac_terr_in;
        cnt_nxt    = cnt_inc;
        crc_nxt    = crc_byte(crc, mac_txd_in);
`ifdef MAC_TX_PAD_EN
        if (mac_tlast_in) state_nxt = (cnt_inc < 11'(MIN_FRAME)) ? PAD : FCS;
`else
        if (mac_tlast_in) state_nxt = FCS;
`endif
      end else if (!phy_tvalid_out) begin
        // Source ran dry mid-frame: poison the wire and swallow the rest of the frame.
        txd_nxt    = 8'h00;
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b1;
        drop_nxt   = 1'b1;
        ifg_nxt    = '0;
        state_nxt  = IFG;
      end
`ifdef MAC_TX_PAD_EN
      PAD: if (out_free) begin
        txd_nxt    = 8'h00;
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b0;
        cnt_nxt    = cnt_inc;
        crc_nxt    = crc_byte(crc, 8'h00);
        if (cnt_inc >= 11'(MIN_FRAME)) state_nxt = FCS;
      end
`endif
      FCS: if (out_free) begin
        txd_nxt    = 8'(fcs >> {sub[1:0], 3'b000});
        tvalid_nxt = 1'b1;
        terr_nxt   = 1'b0;
        sub_nxt    = sub + 3'd1;
        if (sub == 3'd3) begin
          last_fcs_nxt = 1'b1;
          ifg_nxt      = '0;
          state_nxt    = IFG;
        end
      end
      // Gap counting starts only once the final byte has left the register.
      IFG: if (!phy_tvalid_out) begin
        ifg_nxt = ifg_cnt + IW'(1);
        if (ifg_cnt == IW'(IFG_BYTES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge phy_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      phy_txd_out    <= 8'h00;
      phy_tvalid_out <= 1'b0;
      phy_terr_out   <= 1'b0;
      last_fcs       <= 1'b0;
      cnt            <= '0;
      crc            <= '1;
      sub            <= '0;
      ifg_cnt        <= '0;
      err            <= 1'b0;
      drop           <= 1'b0;
    end else begin
      state          <= state_nxt;
      phy_txd_out    <= txd_nxt;
      phy_tvalid_out <= tvalid_nxt;
      phy_terr_out   <= terr_nxt;
      last_fcs       <= last_fcs_nxt;
      cnt            <= cnt_nxt;
      crc            <= crc_nxt;
      sub            <= sub_nxt;
      ifg_cnt        <= ifg_nxt;
      err            <= err_nxt;
      drop           <= drop_nxt;
    end
  end
endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: random and directed frames scored against a queue-based framing/CRC model.
module tb_mac_tx_framer;
  localparam int IFG  = 12;
  localparam int MINF = 60;

  logic       phy_tx_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] mac_txd_in = 8'h00;
  logic       mac_tvalid_in = 1'b0, mac_tlast_in = 1'b0, mac_terr_in = 1'b0;
  logic       phy_tready_in = 1'b1;
  logic       mac_tready_out, phy_tvalid_out, phy_terr_out, tx_done_out;
  logic [7:0] phy_txd_out;

  int vectors = 0, miscompares = 0;
  int cyc = 0, rdy_mode = 0;
  logic [8:0] got_q[$];
  int done_idx = -1, first_vld = -1, last_acc = -1000, done_stray = 0;

  mac_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
    .phy_tx_clk(phy_tx_clk), .sys_rst_n(sys_rst_n),
    .mac_txd_in(mac_txd_in), .mac_tvalid_in(mac_tvalid_in), .mac_tlast_in(mac_tlast_in),
    .mac_terr_in(mac_terr_in), .mac_tready_out(mac_tready_out),
    .phy_txd_out(phy_txd_out), .phy_tvalid_out(phy_tvalid_out), .phy_tready_in(phy_tready_in),
    .phy_terr_out(phy_terr_out), .tx_done_out(tx_done_out));

  always #5 phy_tx_clk = ~phy_tx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every byte the PHY takes, plus where tx_done fired.
  always @(negedge phy_tx_clk) begin
    if (phy_tvalid_out && first_vld < 0) first_vld = cyc;
    if (tx_done_out) begin
      if (phy_tvalid_out && phy_tready_in) done_idx = got_q.size();
      else done_stray++;
    end
    if (phy_tvalid_out && phy_tready_in) begin
      got_q.push_back({phy_terr_out, phy_txd_out});
      last_acc = cyc;
    end
    cyc++;
  end

  always @(posedge phy_tx_clk) begin
    #1;
    case (rdy_mode)
      0:       phy_tready_in = 1'b1;
      1:       phy_tready_in = ~phy_tready_in;
      default: phy_tready_in = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      c ^= {24'h0, b[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send(input logic [7:0] d[$], input int err_at, input int stop_at, input int rst_at);
    int i = 0, budget = 0;
    bit paused = 0, hs;
    @(posedge phy_tx_clk); #1;
    while (i < d.size() && budget < 5000) begin
      if (i == rst_at) begin
        sys_rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 32'(phy_tvalid_out), 0);
        chk("rst_txd", 32'(phy_txd_out), 0);
        chk("rst_terr", 32'(phy_terr_out), 0);
        chk("rst_tready", 32'(mac_tready_out), 0);
        chk("rst_done", 32'(tx_done_out), 0);
        mac_tvalid_in = 0; mac_tlast_in = 0; mac_terr_in = 0;
        @(posedge phy_tx_clk); #2;
        sys_rst_n = 1'b1;
        return;
      end
      if (i == stop_at && !paused) begin
        mac_tvalid_in = 1'b0;
        repeat (4) @(posedge phy_tx_clk);
        #1;
        paused = 1;
      end
      mac_tvalid_in = 1'b1;
      mac_txd_in    = d[i];
      mac_tlast_in  = (i == d.size() - 1);
      mac_terr_in   = (i == err_at);
      @(negedge phy_tx_clk);
      hs = mac_tready_out;
      @(posedge phy_tx_clk); #1;
      if (hs) i++;
      budget++;
    end
    mac_tvalid_in = 0; mac_tlast_in = 0; mac_terr_in = 0;
    if (budget >= 5000) chk("send_timeout", 1, 0);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d[$], input int err_at,
                           input int stop_at, input int rst_at, input bit gap_chk);
    logic [8:0] exp_q[$];
    logic [7:0] body[$];
    logic [31:0] fcs;
    int prev_end, t, gap, exp_done;
    prev_end = last_acc;
    got_q = {}; done_idx = -1; first_vld = -1; done_stray = 0;
    repeat (7) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    if (stop_at >= 0) begin
      for (int k = 0; k < stop_at; k++) exp_q.push_back({1'b0, d[k]});
      exp_q.push_back(9'h100);
    end else begin
      body = d;
`ifdef MAC_TX_PAD_EN
      while (body.size() < MINF) body.push_back(8'h00);
`endif
      foreach (body[k]) exp_q.push_back({(k < d.size() && k == err_at), body[k]});
      fcs = crc32(body) ^ ((err_at >= 0) ? 32'hFFFFFFFF : 32'h0);
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
    end
    send(d, err_at, stop_at, rst_at);
    if (rst_at >= 0) return;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge phy_tx_clk);
      t++;
    end
    chk({name, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[k])
      if (k < got_q.size()) chk($sformatf("%s_b%0d", name, k), 32'(got_q[k]), 32'(exp_q[k]));
    exp_done = (stop_at >= 0) ? -1 : exp_q.size() - 1;
    chk({name, "_done_at"}, done_idx, exp_done);
    chk({name, "_done_stray"}, done_stray, 0);
    if (gap_chk) begin
      gap = first_vld - prev_end - 1;
      chk({name, "_ifg"}, (gap >= IFG) ? IFG : gap, IFG);
    end
  endtask

  initial begin
    logic [7:0] d[$];
    int len, err_at;
    repeat (3) @(posedge phy_tx_clk);
    #1;
    chk("reset_tvalid", 32'(phy_tvalid_out), 0);
    chk("reset_txd", 32'(phy_txd_out), 0);
    chk("reset_terr", 32'(phy_terr_out), 0);
    chk("reset_tready", 32'(mac_tready_out), 0);
    chk("reset_done", 32'(tx_done_out), 0);
    sys_rst_n = 1'b1;

    d = {}; for (int k = 0; k < 60; k++) d.push_back(8'(k));
    run_frame("f60", d, -1, -1, -1, 0);

    d = {}; for (int k = 0; k < 14; k++) d.push_back(8'($urandom));
    run_frame("f14", d, -1, -1, -1, 1);

    rdy_mode = 1;
    d = {}; for (int k = 0; k < 100; k++) d.push_back(8'($urandom));
    run_frame("f100_toggle", d, -1, -1, -1, 1);

    rdy_mode = 0;
    d = {}; for (int k = 0; k < 40; k++) d.push_back(8'($urandom));
    run_frame("underrun", d, -1, 20, -1, 1);

    d = {}; for (int k = 0; k < 64; k++) d.push_back(8'($urandom));
    run_frame("terr", d, 10, -1, -1, 1);

    d = {}; for (int k = 0; k < 64; k++) d.push_back(8'($urandom));
    run_frame("rst_mid", d, -1, -1, 30, 0);
    d = {}; for (int k = 0; k < 50; k++) d.push_back(8'($urandom));
    run_frame("post_rst", d, -1, -1, -1, 0);

    for (int r = 0; r < 8; r++) begin
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 130);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      d = {}; for (int k = 0; k < len; k++) d.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", r), d, err_at, -1, -1, 1);
    end

    rdy_mode = 0;
    got_q = {};
    repeat (40) @(posedge phy_tx_clk);
    chk("tail_quiet", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mac_tx_framer.md
MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

Interface
REQ-001 SHALL have parameter IFG_BYTES, default 12, meaning idle byte-times enforced after each frame's last FCS byte.
REQ-002 SHALL have parameter MIN_FRAME, default 60, meaning minimum byte count of destination-to-pad, excluding FCS.
REQ-003 SHALL have port phy_tx_clk  in  1  transmit byte clock; single clock domain.
REQ-004 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port mac_txd_in  in  8  frame byte, destination MAC onward.
REQ-006 SHALL have port mac_tvalid_in  in  1  mac_txd_in valid.
REQ-007 SHALL have port mac_tlast_in  in  1  last byte of frame.
REQ-008 SHALL have port mac_terr_in  in  1  upstream error flag for this byte.
REQ-009 SHALL have port mac_tready_out  out  1  input byte accepted when high with mac_tvalid_in.
REQ-010 SHALL have port phy_txd_out  out  8  byte to PHY top (phy_txd_in).
REQ-011 SHALL have port phy_tvalid_out  out  1  phy_txd_out valid (phy_tvalid_in).
REQ-012 SHALL have port phy_tready_in  in  1  PHY accepts byte (phy_tready_out).
REQ-013 SHALL have port phy_terr_out  out  1  error marker on current byte (phy_terr_in).
REQ-014 SHALL have port tx_done_out  out  1  one-cycle pulse when last FCS byte is accepted.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-016 SHALL hold one output byte register; it advances only on phy_tvalid_out && phy_tready_in; bytes are never dropped or duplicated.
REQ-017 IDLE -> PREAMBLE on mac_tvalid_in high; first 0x55 on phy_txd_out with phy_tvalid_out high the next cycle.
REQ-018 PREAMBLE SHALL emit exactly seven 0x55 bytes, then SFD emits one 0xD5, then DATA.
REQ-019 mac_tready_out SHALL be high only in DATA while the output register is empty or being accepted this cycle.
REQ-020 DATA SHALL forward each accepted input byte unchanged; 11-bit byte counter increments per byte, saturating at 2047.
REQ-021 On accepted byte with mac_tlast_in: next state PAD if count < MIN_FRAME and padding enabled, else FCS.
REQ-022 PAD SHALL emit 0x00 bytes until count equals MIN_FRAME, then FCS.
REQ-023 CRC SHALL be IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, over DATA and PAD bytes, final complement.
REQ-024 FCS SHALL emit the 4 CRC bytes least-significant byte first, then IFG.
REQ-025 IFG SHALL hold phy_tvalid_out low for IFG_BYTES cycles, then IDLE; mac_tready_out low throughout.
REQ-026 Underrun: in DATA, output register empty and mac_tvalid_in low -> phy_terr_out high on a 0x00 byte, then IFG; rest of input frame discarded through mac_tlast_in with mac_tready_out high.
REQ-027 mac_terr_in high on an accepted byte SHALL set phy_terr_out on that byte and invert all four FCS bytes.
REQ-028 tlast and terr on the same byte SHALL both apply: terr on that byte, inverted FCS.
REQ-029 phy_terr_out SHALL be low on all preamble, SFD, pad and IFG bytes unless REQ-026 applies.

Reset
REQ-030 sys_rst_n low SHALL asynchronously force IDLE, phy_txd_out 0x00, phy_tvalid_out 0, phy_terr_out 0, mac_tready_out 0, tx_done_out 0, counter 0, CRC 0xFFFFFFFF.
REQ-031 Reset mid-frame SHALL abandon the frame; after release the next frame starts with a full preamble.

Configuration
REQ-032 Macro MAC_TX_PAD_EN defined: short frames padded per REQ-021/022.
REQ-033 MAC_TX_PAD_EN undefined: PAD state omitted; FCS follows the last data byte regardless of length.

Verification
REQ-034 60-byte frame 0x00..0x3B, phy_tready_in=1 -> 7x0x55, 0xD5, 60 data, 4 FCS matching software CRC-32 model, tx_done_out pulse, then 12 idle cycles.
REQ-035 14-byte frame, MAC_TX_PAD_EN defined -> 14 data + 46x0x00 + FCS over 60 bytes; undefined -> 14 data + FCS over 14 bytes.
REQ-036 phy_tready_in toggling 1/0 each cycle over 100-byte frame -> identical byte sequence to REQ-034 method; no loss or duplication.
REQ-037 mac_tvalid_in dropped after 20 data bytes -> one 0x00 byte with phy_terr_out=1, then 12 idle cycles, then IDLE.
REQ-038 mac_terr_in=1 on byte 10 of 64-byte frame -> phy_terr_out=1 on that byte only; FCS bytes equal bitwise inverse of the correct FCS.
REQ-039 sys_rst_n pulsed low at data byte 30 -> all outputs at reset values immediately; next frame begins with 7x0x55.
